// File: rtl/rsa_ctrl_pkg.sv
// Shared types and default widths for the RSA run sequencer.
package rsa_ctrl_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    HALT = 2'd3
  } run_state_t;

endpackage

// File: rtl/run_sequencer_if.sv
// Host memory-access handshake: the loader is the master, the sequencer is the slave.
interface run_sequencer_if import rsa_ctrl_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack, host_rdata
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack, host_rdata
  );

endinterface

// File: rtl/run_cycle_counter.sv
// Saturating cycle counter; clr wins over en, holds at all-ones.
module run_cycle_counter import rsa_ctrl_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  // NOTE: registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_count <= '0;
    end else if (en && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/run_sequencer.sv
// Sequences one CPU run and arbitrates the data-memory port between host and CPU.
// Optional RUN watchdog enabled by defining RUN_TIMEOUT_EN.
module run_sequencer import rsa_ctrl_pkg::*; #(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_go,
  input  logic              host_clear,
  run_sequencer_if.slave    host,
  input  logic              cpu_MemWrite,
  input  logic [ADDR_W-1:0] cpu_ALUResult,
  input  logic [DATA_W-1:0] cpu_WriteData,
  input  logic              EndFlag,
  output logic              cpu_start,
  output logic              cpu_reset,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  run_cycles
);

`ifdef RUN_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  run_state_t        r_state;
  logic              r_host_ack;
  logic [DATA_W-1:0] r_host_rdata;
  logic              w_launch;
  logic              w_accept;
  logic              w_timeout_hit;
  logic [CNT_W-1:0]  w_run_cycles;

  // Launch steals the port for this cycle, so a same-cycle request waits.
  assign w_launch      = host_go && ((r_state == IDLE) || (r_state == DONE));
  assign w_accept      = host.host_req && !r_host_ack && (r_state != RUN) && !w_launch;
  assign w_timeout_hit = TIMEOUT_EN && (w_run_cycles == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: if (host_go) r_state <= RUN;
        RUN: begin
          if (EndFlag)            r_state <= DONE;
          else if (w_timeout_hit) r_state <= HALT;
        end
        DONE: begin
          if (host_go)         r_state <= RUN;
          else if (host_clear) r_state <= IDLE;
        end
        HALT: if (host_clear) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Ack and read data are registered, so an access accepted just before launch still completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_host_ack   <= 1'b0;
      r_host_rdata <= '0;
    end else begin
      r_host_ack <= w_accept;
      if (w_accept) r_host_rdata <= mem_rdata;
    end
  end

  run_cycle_counter #(.CNT_W(CNT_W)) u_run_cycle_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (w_launch),
    .en    (r_state == RUN),
    .count (w_run_cycles)
  );

  // NOTE: every output of a combinational block gets a value on every path, else a latch is inferred.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = host.host_addr;
    mem_wdata = host.host_wdata;
    if (r_state == RUN) begin
      mem_we    = cpu_MemWrite;
      mem_addr  = cpu_ALUResult;
      mem_wdata = cpu_WriteData;
    end else begin
      mem_we    = host.host_we && w_accept;
    end
  end

  assign host.host_ack   = r_host_ack;
  assign host.host_rdata = r_host_rdata;
  assign cpu_reset       = (r_state != RUN);
  assign cpu_start       = (r_state == RUN);
  assign busy            = (r_state == RUN);
  assign done            = (r_state == DONE);
  assign timeout         = TIMEOUT_EN && (r_state == HALT);
  assign run_cycles      = w_run_cycles;

endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench for run_sequencer: memory and CPU models plus a host-read scoreboard.
`timescale 1ns/1ps
module tb_run_sequencer;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        host_go = 1'b0;
  logic        host_clear = 1'b0;
  logic        cpu_MemWrite, EndFlag, cpu_start, cpu_reset, mem_we;
  logic        busy, done, timeout;
  logic [31:0] cpu_ALUResult, cpu_WriteData, mem_addr, mem_wdata, mem_rdata, run_cycles;

  run_sequencer_if #(.ADDR_W(32), .DATA_W(32)) hif ();

  always #5 clk = ~clk;

  run_sequencer #(.ADDR_W(32), .DATA_W(32), .CNT_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk           (clk),
    .reset         (reset),
    .host_go       (host_go),
    .host_clear    (host_clear),
    .host          (hif),
    .cpu_MemWrite  (cpu_MemWrite),
    .cpu_ALUResult (cpu_ALUResult),
    .cpu_WriteData (cpu_WriteData),
    .EndFlag       (EndFlag),
    .cpu_start     (cpu_start),
    .cpu_reset     (cpu_reset),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .busy          (busy),
    .done          (done),
    .timeout       (timeout),
    .run_cycles    (run_cycles)
  );

  // Data memory model: combinational read, write on rising edge.
  logic [31:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  // CPU model: counts cycles since start, raises EndFlag on RUN cycle end_after (0 = never).
  int cpu_cnt = 0;
  int end_after = 0;
  always @(posedge clk) cpu_cnt <= cpu_start ? cpu_cnt + 1 : 0;
  assign EndFlag       = cpu_start && (end_after != 0) && (cpu_cnt == end_after - 1);
  assign cpu_ALUResult = 32'h100 + 32'(cpu_cnt) * 4;
  assign cpu_WriteData = 32'hC000_0000 | 32'(cpu_cnt);
  assign cpu_MemWrite  = cpu_start && cpu_cnt[0];

  typedef struct {
    bit          is_read;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every ack must match a queued access; reads also compare data.
  always @(negedge clk) begin
    if (hif.host_ack === 1'b1) begin
      if (sb.size() == 0) begin
        check("stray_ack", hif.host_ack, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.is_read) check("host_rdata", hif.host_rdata, e.data);
      end
    end
  end

  task automatic check_reset_outputs(string tag);
    check({tag, "_cpu_reset"}, cpu_reset, 1'b1);
    check({tag, "_cpu_start"}, cpu_start, 1'b0);
    check({tag, "_ack"}, hif.host_ack, 1'b0);
    check({tag, "_rdata"}, hif.host_rdata, 32'h0);
    check({tag, "_run_cycles"}, run_cycles, 32'h0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_timeout"}, timeout, 1'b0);
  endtask

  // Single host access from a host-owned state; ack expected one cycle after accept.
  task automatic host_access(bit we, logic [31:0] addr, logic [31:0] data, string tag);
    int waited = 0;
    hif.host_req   = 1'b1;
    hif.host_we    = we;
    hif.host_addr  = addr;
    hif.host_wdata = we ? data : 32'h0;
    sb.push_back('{is_read: !we, data: data});
    #1;
    check({tag, "_mem_we"}, mem_we, we);
    check({tag, "_mem_addr"}, mem_addr, addr);
    do begin
      @(negedge clk);
      waited++;
    end while (hif.host_ack !== 1'b1 && waited < 100);
    check({tag, "_ack_lat"}, waited, 1);
    hif.host_req = 1'b0;
    hif.host_we  = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic pulse_go();
    host_go = 1'b1;
    @(negedge clk);
    host_go = 1'b0;
  endtask

  task automatic pulse_clear();
    host_clear = 1'b1;
    @(negedge clk);
    host_clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acks;
    logic [2:0] pat;

    foreach (mem[i]) mem[i] = 32'h0;
    hif.host_req   = 1'b0;
    hif.host_we    = 1'b0;
    hif.host_addr  = 32'h0;
    hif.host_wdata = 32'h0;

    // Power-on reset
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;
    @(negedge clk);

    // Preload and read back in IDLE
    host_access(1'b1, 32'h10, 32'h41, "pre_wr");
    check("pre_cpu_reset_wr", cpu_reset, 1'b1);
    @(negedge clk);
    host_access(1'b0, 32'h10, 32'h41, "pre_rd");
    check("pre_cpu_reset_rd", cpu_reset, 1'b1);
    @(negedge clk);

    // Held request: at most one access every two cycles
    hif.host_req  = 1'b1;
    hif.host_we   = 1'b0;
    hif.host_addr = 32'h10;
    sb.push_back('{is_read: 1'b1, data: 32'h41});
    sb.push_back('{is_read: 1'b1, data: 32'h41});
    for (int i = 2; i >= 0; i--) begin
      @(negedge clk);
      pat[i] = hif.host_ack;
    end
    hif.host_req = 1'b0;
    check("rate_ack_pattern", pat, 3'b101);
    @(negedge clk);

    // Normal run: EndFlag on RUN cycle 50
    end_after = 50;
    pulse_go();
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      if (n == 10) begin
        check("mux_addr", mem_addr, 32'h100 + 32'(4 * (n - 1)));
        check("mux_wdata", mem_wdata, 32'hC000_0000 | 32'(n - 1));
        check("mux_we", mem_we, 1'b1);
      end
      @(negedge clk);
    end
    check("run_busy_cycles", n, 50);
    check("run_done", done, 1'b1);
    check("run_cpu_start", cpu_start, 1'b0);
    check("run_cpu_reset", cpu_reset, 1'b1);
    check("run_cycles", run_cycles, 32'd50);
    check("cpu_store", mem[73], 32'hC000_0009);
    repeat (2) @(negedge clk);
    check("run_cycles_frozen", run_cycles, 32'd50);

    pulse_clear();
    check("clear_done", done, 1'b0);
    check("clear_cpu_reset", cpu_reset, 1'b1);

    // Collision + contention: go and read request together in IDLE
    end_after = 20;
    host_go       = 1'b1;
    hif.host_req  = 1'b1;
    hif.host_we   = 1'b0;
    hif.host_addr = 32'h10;
    sb.push_back('{is_read: 1'b1, data: 32'h41});
    @(negedge clk);
    host_go = 1'b0;
    check("coll_busy", busy, 1'b1);
    n = 0;
    acks = 0;
    while (busy === 1'b1 && n < 1000) begin
      if (hif.host_ack === 1'b1) acks++;
      if (n == 4) check("cont_mux_addr", mem_addr, 32'h100 + 32'(4 * n));
      n++;
      @(negedge clk);
    end
    check("cont_run_len", n, 20);
    check("cont_no_ack_in_run", acks, 0);
    check("cont_done", done, 1'b1);
    check("cont_ack_not_yet", hif.host_ack, 1'b0);
    @(negedge clk);
    check("cont_ack_after_done", hif.host_ack, 1'b1);
    hif.host_req = 1'b0;
    @(negedge clk);

    // go + clear in DONE: go wins, counter restarts
    end_after  = 5;
    host_go    = 1'b1;
    host_clear = 1'b1;
    @(negedge clk);
    host_go    = 1'b0;
    host_clear = 1'b0;
    check("relaunch_busy", busy, 1'b1);
    check("relaunch_cnt_clr", run_cycles, 32'd0);
    count_busy(n);
    check("relaunch_len", n, 5);
    check("relaunch_cycles", run_cycles, 32'd5);

`ifdef RUN_TIMEOUT_EN
    // Watchdog: EndFlag never rises
    end_after = 0;
    pulse_go();
    count_busy(n);
    check("tmo_len", n, TMO);
    check("tmo_timeout", timeout, 1'b1);
    check("tmo_done", done, 1'b0);
    check("tmo_cpu_reset", cpu_reset, 1'b1);
    check("tmo_cycles", run_cycles, 32'(TMO));
    pulse_go();
    check("halt_ignores_go", busy, 1'b0);
    check("halt_stays", timeout, 1'b1);
    host_access(1'b0, 32'h10, 32'h41, "halt_rd");
    pulse_clear();
    check("halt_clear", timeout, 1'b0);
    // EndFlag on the last allowed cycle wins
    end_after = TMO;
    pulse_go();
    count_busy(n);
    check("tmo_edge_len", n, TMO);
    check("tmo_edge_done", done, 1'b1);
    check("tmo_edge_timeout", timeout, 1'b0);
`else
    check("no_tmo_timeout", timeout, 1'b0);
`endif

    pulse_clear();

    // Reset in the middle of RUN
    end_after = 0;
    pulse_go();
    repeat (5) @(negedge clk);
    check("mid_run_busy", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_run");
    reset = 1'b0;
    @(negedge clk);
    check("rst_run_idle", busy, 1'b0);

    // Reset coinciding with an accepted access drops it
    hif.host_req  = 1'b1;
    hif.host_we   = 1'b0;
    hif.host_addr = 32'h10;
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_acc");
    hif.host_req = 1'b0;
    reset = 1'b0;
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (hif.host_ack === 1'b1) acks++;
    end
    check("rst_acc_no_ack", acks, 0);

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
